// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/optional-parity/stop framing with
// 3-sample majority voting per bit and per-frame parity and stop-bit checking.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CHECK
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              edge_q, edge_d;
    logic [5:0]              pre_q, pre_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic [2:0]              smp_q, smp_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    start_bad_q, start_bad_d;
    logic                    par_bad_q, par_bad_d;
    logic                    stop_bad_q, stop_bad_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_err_q, par_err_d;
    logic                    stp_err_q, stp_err_d;

    logic [5:0] mid;
    logic       edge_last;
    logic       in_window;
    logic       at_decide;
    logic       waiting;
    logic       start_det;
    logic       maj;

    function automatic logic [5:0] decode_prescale(input logic [5:0] p);
        case (p)
            6'd16:   return 6'd16;
            6'd32:   return 6'd32;
            default: return 6'd8;
        endcase
    endfunction

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    assign mid       = {1'b0, pre_q[5:1]};
    assign edge_last = (edge_q == pre_q - 6'd1);
    assign in_window = (edge_q >= mid - 6'd1) && (edge_q <= mid + 6'd1);
    assign at_decide = (edge_q == mid + 6'd2);
    assign waiting   = (state_q == S_IDLE) || (state_q == S_CHECK);
    // A low line seen while waiting is edge 0 of a new start bit.
    assign start_det = waiting && !RX_IN;
    assign maj       = majority3(smp_q);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!RX_IN) state_d = S_START;
            end
            S_START: begin
                if (edge_last) state_d = start_bad_q ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (edge_last && (bit_cnt_q == LAST_BIT)) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (edge_last) state_d = S_STOP;
            end
            S_STOP: begin
                if (edge_last) state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = RX_IN ? S_IDLE : S_START;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        edge_d       = edge_q;
        pre_d        = pre_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        smp_d        = smp_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        start_bad_d  = start_bad_q;
        par_bad_d    = par_bad_q;
        stop_bad_d   = stop_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;

        if (start_det) begin
            edge_d      = 6'd1;
            pre_d       = decode_prescale(Prescale);
            par_en_d    = PAR_EN;
            par_typ_d   = PAR_TYP;
            smp_d       = 3'b000;
            bit_cnt_d   = '0;
            start_bad_d = 1'b0;
            par_bad_d   = 1'b0;
            stop_bad_d  = 1'b0;
        end else if (waiting) begin
            edge_d = 6'd0;
        end else begin
            edge_d = edge_last ? 6'd0 : edge_q + 6'd1;
            if (in_window) smp_d = {smp_q[1:0], RX_IN};

            // The three window samples are all registered by the decision edge.
            if (at_decide) begin
                case (state_q)
                    S_START:  start_bad_d = maj;
                    S_DATA:   shift_d     = {maj, shift_q[DATA_WIDTH-1:1]};
                    S_PARITY: par_bad_d   = (maj != ((^shift_q) ^ par_typ_q));
                    S_STOP:   stop_bad_d  = !maj;
                    default:  ;
                endcase
            end

            if ((state_q == S_DATA) && edge_last) bit_cnt_d = bit_cnt_q + 1'b1;

            // Results are registered on the way into CHECK so they are visible there.
            if ((state_q == S_STOP) && edge_last) begin
                par_err_d = par_en_q & par_bad_q;
                stp_err_d = stop_bad_q;
                if (!(par_en_q & par_bad_q) && !stop_bad_q) begin
                    p_data_d     = shift_q;
                    data_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_q       <= 6'd0;
            pre_q        <= 6'd8;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            smp_q        <= 3'b000;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            start_bad_q  <= 1'b0;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            edge_q       <= edge_d;
            pre_q        <= pre_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            smp_q        <= smp_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            start_bad_q  <= start_bad_d;
            par_bad_q    <= par_bad_d;
            stop_bad_q   <= stop_bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the payload bits per frame.
REQ-002 SHALL have port CLK  input  1  receiver oversampling clock.
REQ-003 SHALL have port RST  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port RX_IN  input  1  serial line; idle high; already synchronous to CLK, with no internal synchronizer.
REQ-005 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-006 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-007 SHALL have port Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-008 SHALL have port P_DATA  output  DATA_WIDTH  last correctly received payload.
REQ-009 SHALL have port DATA_VALID  output  1  one-cycle pulse when a good frame is delivered.
REQ-010 SHALL have port PAR_ERR  output  1  parity mismatch flag for the last frame.
REQ-011 SHALL have port STP_ERR  output  1  stop bit sampled low on the last frame.

Function
REQ-012 Frame format SHALL be: start bit (0), then DATA_WIDTH data bits LSB first, then an optional parity bit, then one stop bit (1).
REQ-013 Each bit SHALL occupy exactly P CLK cycles, where P is Prescale; an edge counter runs 0..P-1 per bit and a bit counter indexes the bits.
REQ-014 Prescale values other than 8, 16 or 32 SHALL be treated as 8.
REQ-015 PAR_EN, PAR_TYP and Prescale SHALL be captured at start detection and held constant for the whole frame.
REQ-016 Each bit value SHALL be the majority of three samples taken at edge counts P/2-1, P/2 and P/2+1; the decision SHALL be registered at edge count P/2+2.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and CHECK.
REQ-018 In IDLE, RX_IN=0 SHALL move the FSM to START; that same cycle counts as edge 0 of the start bit.
REQ-019 START: if the majority-sampled start bit is 1 (glitch), the FSM SHALL return to IDLE at edge P-1 with no flags changed; otherwise it SHALL go to DATA at edge P-1.
REQ-020 DATA: data bits SHALL be shifted into an internal register LSB first; after bit DATA_WIDTH-1 ends, the FSM SHALL go to PARITY if PAR_EN=1, else to STOP.
REQ-021 PARITY: the sampled bit SHALL be compared with the computed value, where even parity = XOR of the data bits and odd parity = its inverse; the FSM SHALL go to STOP at edge P-1.
REQ-022 STOP: a sampled value of 0 SHALL mark a stop error; at edge P-1 the FSM SHALL go to CHECK.
REQ-023 CHECK SHALL last one cycle and SHALL:
  - update PAR_ERR and STP_ERR (PAR_ERR forced 0 when PAR_EN=0);
  - when both flags are 0, load P_DATA and pulse DATA_VALID high for exactly that one cycle.
REQ-024 Leaving CHECK, the FSM SHALL go to START if RX_IN=0 (back-to-back frame, that cycle is edge 0), else to IDLE.
REQ-025 On any error, P_DATA SHALL keep its previous value and DATA_VALID SHALL stay 0.
REQ-026 PAR_ERR and STP_ERR SHALL hold until the next CHECK.
REQ-027 Latency: DATA_VALID SHALL rise F*P cycles after the start-detect cycle, where F = DATA_WIDTH+2 (+1 if parity is enabled).
REQ-028 RX_IN changes outside the sampling window SHALL have no effect.
REQ-029 A line held low (break condition) SHALL produce STP_ERR=1 and then an immediate re-entry into START.

Reset
REQ-030 RST=0 SHALL asynchronously force the FSM to IDLE and clear all counters, the shift register, P_DATA, DATA_VALID, PAR_ERR and STP_ERR.
REQ-031 RST asserted mid-frame SHALL abort the frame and produce no DATA_VALID.
REQ-032 After RST is released, the receiver SHALL wait in IDLE for a falling RX_IN.

Verification
REQ-033 P=8, PAR_EN=0, byte 0xA5 -> DATA_VALID pulses once 80 cycles after start detect, P_DATA=0xA5, both error flags 0.
REQ-034 P=16, PAR_EN=1, PAR_TYP=0, byte 0x3C with parity bit 0 -> P_DATA=0x3C, PAR_ERR=0; the same frame with parity bit 1 -> PAR_ERR=1, no DATA_VALID, P_DATA unchanged.
REQ-035 P=32, stop bit driven 0 on byte 0x81 -> STP_ERR=1, no DATA_VALID; the next good frame 0x7E -> both flags clear and P_DATA=0x7E.
REQ-036 A 3-cycle low glitch on RX_IN while in IDLE (P=16) -> return to IDLE, no outputs change.
REQ-037 Two back-to-back frames 0x55 then 0xAA with no idle gap (P=8, odd parity) -> two DATA_VALID pulses exactly 88 cycles apart with the correct data.
REQ-038 RST pulsed low during data bit 4 -> all outputs 0 immediately; a following frame 0x0F is received correctly.
